// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART TX arbiter slice: the
//               controller state enumeration, default parameter values and a
//               constant-evaluable ceiling-log2 helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DBIT   = 8;
    localparam int NREQ   = 4;
    localparam int MAXLEN = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Ceiling log2, never less than 1 so that derived vectors are never
    // zero-width.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin priority search. Starting at ptr
//               and wrapping modulo nreq, returns the first requester whose
//               bit is set in req.
// Ports       : req   - request vector (nreq bits)
//               ptr   - search start index
//               grant - index of the winning requester (ptr if none)
//               any   - at least one request is set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import uart_pkg::*;
#(
    parameter int nreq = NREQ
) (
    input  logic [nreq-1:0]         req,
    input  logic [clog2(nreq)-1:0]  ptr,
    output logic [clog2(nreq)-1:0]  grant,
    output logic                    any
);

    localparam int IW = clog2(nreq);
    localparam logic [IW:0] C_NREQ = (IW+1)'(nreq);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_idx;

    // Walk offsets from the farthest to the nearest so the candidate closest
    // to ptr is the last one written and therefore wins.
    always_comb begin
        grant = ptr;
        any   = |req;
        w_sum = '0;
        w_idx = '0;
        for (int k = nreq - 1; k >= 0; k--) begin
            w_sum = {1'b0, ptr} + (IW+1)'(k);
            if (w_sum >= C_NREQ) begin
                w_sum = w_sum - C_NREQ;
            end
            w_idx = w_sum[IW-1:0];
            if (req[w_idx]) begin
                grant = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arb
// Description : Round-robin arbiter that lets nreq byte-stream requesters
//               share one UART TX FIFO. A grant is held for a whole message
//               (until req_last or maxlen bytes), with one idle cycle between
//               grants.
// Ports       : clk        - clock, rising edge
//               rst        - asynchronous reset, active low
//               req_valid  - per-requester byte valid
//               req_data   - per-requester byte, requester i at [i*dbit +: dbit]
//               req_last   - per-requester end-of-message marker
//               req_ready  - per-requester byte accepted strobe
//               full       - UART TX FIFO full
//               wr         - UART TX FIFO write strobe
//               wr_data    - UART TX FIFO write data
//               busy       - grant held
//               owner      - current grant holder
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int dbit   = DBIT,
    parameter int nreq   = NREQ,
    parameter int maxlen = MAXLEN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [nreq-1:0]         req_valid,
    input  logic [nreq*dbit-1:0]    req_data,
    input  logic [nreq-1:0]         req_last,
    output logic [nreq-1:0]         req_ready,
    input  logic                    full,
    output logic                    wr,
    output logic [dbit-1:0]         wr_data,
    output logic                    busy,
    output logic [clog2(nreq)-1:0]  owner
);

    localparam int IW = clog2(nreq);
    localparam int CW = clog2(maxlen + 1);
    localparam logic [CW-1:0] C_MAXLEN   = CW'(maxlen);
    localparam logic [IW-1:0] C_LAST_IDX = IW'(nreq - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_rr_ptr;
    logic [IW-1:0]   w_rr_ptr_nxt;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   w_owner_nxt;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_nxt;
    logic [CW-1:0]   w_count_inc;
    logic [IW-1:0]   w_pick;
    logic            w_any;
    logic            w_xfer;
    logic [dbit-1:0] w_data_arr [nreq];

    generate
        for (genvar g = 0; g < nreq; g++) begin : g_unpack
            assign w_data_arr[g] = req_data[g*dbit +: dbit];
        end
    endgenerate

    rr_pick #(
        .nreq (nreq)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (r_rr_ptr),
        .grant (w_pick),
        .any   (w_any)
    );

    assign w_count_inc = r_count + CW'(1);
    assign wr_data     = w_data_arr[r_owner];
    assign busy        = (r_state == STREAM);
    assign owner       = r_owner;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_owner  <= w_owner_nxt;
            r_count  <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        w_owner_nxt  = r_owner;
        w_count_nxt  = r_count;
        req_ready    = '0;
        wr           = 1'b0;
        w_xfer       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_owner_nxt = w_pick;
                    w_count_nxt = '0;
                    w_state_nxt = STREAM;
                end
            end
            STREAM: begin
                // The grant is held while the owner is not valid; only
                // last or the length limit releases it.
                req_ready[r_owner] = !full;
                w_xfer             = req_valid[r_owner] & !full;
                wr                 = w_xfer;
                if (w_xfer) begin
                    w_count_nxt = w_count_inc;
                    if (req_last[r_owner] || (w_count_inc == C_MAXLEN)) begin
                        w_state_nxt  = IDLE;
                        w_rr_ptr_nxt = (r_owner == C_LAST_IDX) ? '0 : r_owner + IW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
